if_id_latch: RTL and testbench

//  IF/ID pipeline register between fetch and decode. Captures fetched instruction and PC+2,

---
 rtl/if_id_latch.sv | 100 ++++++++++
 tb/tb_if_id_latch.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/if_id_latch.sv
// IF/ID pipeline register. It captures the fetched instruction and PC+2 and
// gives decode the opcode and a validIns qualifier. The block also handles
// stall (hold), flush (bubble), fetch bubbles, sticky HALT detection and a
// saturating stall-cycle counter.
module if_id_latch #(
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [INSTR_W-1:0] pcInc_in,
    input  logic               fetch_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_out,
    output logic [INSTR_W-1:0] pcInc_out,
    output logic [4:0]         opcode,
    output logic               validIns,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [4:0]       OP_HALT  = 5'b0_0000;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pcinc_q, pcinc_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halt_seen;

    // The opcode is the top five bits of the held instruction.
    assign opcode = instr_q[INSTR_W-1 -: 5];

    // A valid HALT leaves this stage on an edge that neither stalls nor flushes.
    assign halt_seen = valid_q && (opcode == OP_HALT) && !stall && !flush;

    // Next-state logic. The branches follow edge priority: halted, flush, stall, load.
    always_comb begin
        instr_d  = instr_q;
        pcinc_d  = pcinc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (halted_q) begin
            // Once halted, only bubbles pass. PC+2 stays frozen for debug visibility.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pcinc_d = '0;
        end else if (stall) begin
            // Count only stalls that hold a real instruction, not bubbles.
            if (valid_q && (cnt_q != CNT_MAX))
                cnt_d = cnt_q + CNT_ONE;
        end else begin
            pcinc_d = pcInc_in;
            if (fetch_valid && !halt_seen) begin
                instr_d = instr_in;
                valid_d = 1'b1;
            end else begin
                // A fetch bubble, or the edge where the HALT leaves:
                // either way the stage holds nothing real.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            if (halt_seen)
                halted_d = 1'b1;
        end
    end

    // State registers. An asynchronous reset returns the stage to an empty NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= NOP_INSTR;
            pcinc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            instr_q  <= instr_d;
            pcinc_q  <= pcinc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instr_out = instr_q;
    assign pcInc_out = pcinc_q;
    assign validIns  = valid_q;
    assign halted    = halted_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_latch.sv
// Directed testbench for if_id_latch. It covers reset, load, stall and flush,
// bubbles, HALT detection and squash, and counter saturation.
module tb_if_id_latch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] instr_in = 16'h0000;
    logic [15:0] pcInc_in = 16'h0000;
    logic        fetch_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] pcInc_out;
    logic [4:0]  opcode;
    logic        validIns;
    logic        halted;
    logic [7:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_latch #(.INSTR_W(16), .NOP_INSTR(16'h0800), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pcInc_in(pcInc_in),
        .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
        .instr_out(instr_out), .pcInc_out(pcInc_out), .opcode(opcode),
        .validIns(validIns), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] i, input logic [15:0] p, input logic fv,
                         input logic st, input logic fl);
        instr_in = i; pcInc_in = p; fetch_valid = fv; stall = st; flush = fl;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (instr_out !== 16'h0800) begin n_fail++; $display("FAIL reset_instr: got %h exp 0800", instr_out); end
        n_checks++; if (pcInc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h exp 0000", pcInc_out); end
        n_checks++; if (validIns !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", validIns); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", halted); end
        n_checks++; if (stall_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h exp 00", stall_cnt); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        drive(16'hD8A4, 16'h0010, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (instr_out !== 16'hD8A4) begin n_fail++; $display("FAIL load_instr: got %h exp d8a4", instr_out); end
        n_checks++; if (opcode !== 5'b1_1011) begin n_fail++; $display("FAIL load_opcode: got %b exp 11011", opcode); end
        n_checks++; if (pcInc_out !== 16'h0010) begin n_fail++; $display("FAIL load_pc: got %h exp 0010", pcInc_out); end
        n_checks++; if (validIns !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b exp 1", validIns); end
    endtask

    task automatic test_stall_flush();
        drive(16'h1234, 16'h0099, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        n_checks++; if (instr_out !== 16'hD8A4) begin n_fail++; $display("FAIL stall_instr: got %h exp d8a4", instr_out); end
        n_checks++; if (pcInc_out !== 16'h0010) begin n_fail++; $display("FAIL stall_pc: got %h exp 0010", pcInc_out); end
        n_checks++; if (validIns !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b exp 1", validIns); end
        n_checks++; if (stall_cnt !== 8'd3) begin n_fail++; $display("FAIL stall_cnt3: got %0d exp 3", stall_cnt); end
        drive(16'h1234, 16'h0099, 1'b1, 1'b1, 1'b1);
        tick();
        n_checks++; if (instr_out !== 16'h0800) begin n_fail++; $display("FAIL flush_instr: got %h exp 0800", instr_out); end
        n_checks++; if (validIns !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", validIns); end
        n_checks++; if (pcInc_out !== 16'h0000) begin n_fail++; $display("FAIL flush_pc: got %h exp 0000", pcInc_out); end
        n_checks++; if (stall_cnt !== 8'd3) begin n_fail++; $display("FAIL flush_cnt: got %0d exp 3", stall_cnt); end
        drive(16'h1234, 16'h0099, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (stall_cnt !== 8'd3) begin n_fail++; $display("FAIL stall_bubble_cnt: got %0d exp 3", stall_cnt); end
    endtask

    task automatic test_bubble();
        drive(16'h4123, 16'h0020, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (instr_out !== 16'h0800) begin n_fail++; $display("FAIL bubble_instr: got %h exp 0800", instr_out); end
        n_checks++; if (validIns !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b exp 0", validIns); end
        n_checks++; if (pcInc_out !== 16'h0020) begin n_fail++; $display("FAIL bubble_pc: got %h exp 0020", pcInc_out); end
    endtask

    task automatic test_halt_squash();
        drive(16'h0000, 16'h0030, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (opcode !== 5'b0_0000 || validIns !== 1'b1) begin n_fail++; $display("FAIL halt_load: got op %b v %b exp 00000/1", opcode, validIns); end
        drive(16'h0000, 16'h0030, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_squash: got %b exp 0", halted); end
        drive(16'h4123, 16'h0032, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (validIns !== 1'b1 || instr_out !== 16'h4123) begin n_fail++; $display("FAIL post_squash_load: got %h/%b exp 4123/1", instr_out, validIns); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL post_squash_halted: got %b exp 0", halted); end
    endtask

    task automatic test_halt();
        drive(16'h0000, 16'h0040, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'h4123, 16'h0040, 1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_wait: got %b exp 0", halted); end
        n_checks++; if (stall_cnt !== 8'd4) begin n_fail++; $display("FAIL halt_stall_cnt: got %0d exp 4", stall_cnt); end
        drive(16'h4123, 16'h0040, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b exp 1", halted); end
        n_checks++; if (validIns !== 1'b0 || instr_out !== 16'h0800) begin n_fail++; $display("FAIL halt_edge_nop: got %h/%b exp 0800/0", instr_out, validIns); end
        tick();
        n_checks++; if (validIns !== 1'b0 || instr_out !== 16'h0800) begin n_fail++; $display("FAIL halted_block: got %h/%b exp 0800/0", instr_out, validIns); end
        drive(16'h4123, 16'h0044, 1'b1, 1'b0, 1'b1);
        tick();
        n_checks++; if (pcInc_out !== 16'h0040) begin n_fail++; $display("FAIL halted_pc_hold: got %h exp 0040", pcInc_out); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted_sticky: got %b exp 1", halted); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (halted !== 1'b0 || stall_cnt !== 8'd0 || instr_out !== 16'h0800) begin n_fail++; $display("FAIL halt_async_rst: got h %b c %0d i %h exp 0/0/0800", halted, stall_cnt, instr_out); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        drive(16'h1111, 16'h0060, 1'b1, 1'b0, 1'b0);
        tick();
        drive(16'h2222, 16'h0062, 1'b1, 1'b1, 1'b0);
        repeat (254) tick();
        n_checks++; if (stall_cnt !== 8'hFE) begin n_fail++; $display("FAIL sat_254: got %h exp fe", stall_cnt); end
        repeat (46) tick();
        n_checks++; if (stall_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_300: got %h exp ff", stall_cnt); end
        n_checks++; if (instr_out !== 16'h1111 || validIns !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got %h/%b exp 1111/1", instr_out, validIns); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (stall_cnt !== 8'h00 || validIns !== 1'b0) begin n_fail++; $display("FAIL stall_async_rst: got %h/%b exp 00/0", stall_cnt, validIns); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall_flush();
        test_bubble();
        test_halt_squash();
        test_halt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
